// File: rtl/mem_pkg.sv
// Shared types for the data memory responder: FSM state encoding, request op
// encoding and default bus widths.
package mem_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10,
        ST_HOLD = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        OP_RD  = 2'b00,
        OP_WR  = 2'b01,
        OP_BAD = 2'b10
    } op_t;

    // Both strobes at once is a conflicting request and never touches storage.
    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && wr) begin
            return OP_BAD;
        end else if (wr) begin
            return OP_WR;
        end
        return OP_RD;
    endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W word storage: synchronous write, combinational read.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with programmable wait states and a one-cycle
// mem_ready pulse; rejects out-of-range and conflicting requests via mem_err.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_ready,
    output logic              mem_busy,
    output logic              mem_err
);

    localparam int              IDX_W    = $clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

    state_t            r_state, w_state_next;
    logic [3:0]        r_cnt, w_cnt_next;
    op_t               r_op, w_op_cur;
    logic [ADDR_W-1:0] r_addr, w_addr_cur;
    logic [DATA_W-1:0] r_wdata, w_wdata_cur;
    logic [DATA_W-1:0] r_rdata, w_arr_rdata;
    logic              r_ready, r_busy, r_err;
    logic              w_req, w_accept, w_enter_resp, w_ok, w_we;

    assign w_req = mem_read | mem_write;

    // With LATENCY=1 the response edge is the accept edge, so the live
    // inputs stand in for the not-yet-latched request.
    always_comb begin
        w_op_cur    = r_op;
        w_addr_cur  = r_addr;
        w_wdata_cur = r_wdata;
        if (r_state == ST_IDLE) begin
            w_op_cur    = decode_op(mem_read, mem_write);
            w_addr_cur  = addr;
            w_wdata_cur = wdata;
        end
    end

    assign w_ok = ({1'b0, w_addr_cur} < DEPTH_L) && (w_op_cur != OP_BAD);
    assign w_we = w_enter_resp && w_ok && (w_op_cur == OP_WR);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_accept   = 1'b1;
                    w_cnt_next = CNT_INIT;
                    if (LATENCY == 1) begin
                        w_state_next = ST_RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_RESP;
                    w_enter_resp = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!w_req) begin
                    w_state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_op    <= OP_RD;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_ready <= w_enter_resp;
            r_busy  <= (w_state_next != ST_IDLE);
            r_err   <= w_enter_resp && !w_ok;
            if (w_accept) begin
                r_op    <= w_op_cur;
                r_addr  <= w_addr_cur;
                r_wdata <= w_wdata_cur;
            end
            if (w_enter_resp) begin
                r_rdata <= (w_ok && (w_op_cur == OP_RD)) ? w_arr_rdata : '0;
            end
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_addr_cur[IDX_W-1:0]),
        .i_wdata (w_wdata_cur),
        .i_raddr (w_addr_cur[IDX_W-1:0]),
        .o_rdata (w_arr_rdata)
    );

    assign rdata     = r_rdata;
    assign mem_ready = r_ready;
    assign mem_busy  = r_busy;
    assign mem_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Drives one LATENCY=2 and one LATENCY=1 responder with identical requests and
// checks both against a word-array model of the memory.
module tb_data_mem_responder;

    logic        clk;
    logic        reset_n;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata2, rdata1;
    logic        ready2, ready1, busy2, busy1, err2, err1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] m2    [256];
    logic [15:0] m1    [256];
    bit          known [256];

    data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata2), .mem_ready(ready2),
        .mem_busy(busy2), .mem_err(err2)
    );

    data_mem_responder #(.DATA_W(16), .ADDR_W(16), .DEPTH(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .rdata(rdata1), .mem_ready(ready1),
        .mem_busy(busy1), .mem_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One request, held for 3+extra cycles after the accept edge, then dropped.
    // Called and returns on a falling edge.
    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] a,
                          input logic [15:0] d, input int extra, input bit churn,
                          input string tag);
        bit          err;
        bit          chk1, chk2;
        logic [15:0] exp1, exp2;
        err  = (rd && wr) || (a >= 16'd256);
        exp1 = 16'h0;
        exp2 = 16'h0;
        chk1 = err;
        chk2 = err;
        if (!err && rd && known[a[7:0]]) begin
            exp1 = m1[a[7:0]];
            exp2 = m2[a[7:0]];
            chk1 = 1'b1;
            chk2 = 1'b1;
        end
        $display("txn %s rd=%0b wr=%0b addr=%h wdata=%h err_exp=%0b", tag, rd, wr, a, d, err);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        for (int k = 1; k <= 3 + extra; k++) begin
            @(negedge clk);
            total_cnt++; if (ready2 !== (k == 2)) $display("FAIL %s ready2 k=%0d got %b want %b", tag, k, ready2, (k == 2)); else pass_cnt++;
            total_cnt++; if (ready1 !== (k == 1)) $display("FAIL %s ready1 k=%0d got %b want %b", tag, k, ready1, (k == 1)); else pass_cnt++;
            total_cnt++; if (busy2 !== 1'b1) $display("FAIL %s busy2 k=%0d got %b want 1", tag, k, busy2); else pass_cnt++;
            total_cnt++; if (busy1 !== 1'b1) $display("FAIL %s busy1 k=%0d got %b want 1", tag, k, busy1); else pass_cnt++;
            total_cnt++; if (err2 !== (err && k == 2)) $display("FAIL %s err2 k=%0d got %b want %b", tag, k, err2, (err && k == 2)); else pass_cnt++;
            total_cnt++; if (err1 !== (err && k == 1)) $display("FAIL %s err1 k=%0d got %b want %b", tag, k, err1, (err && k == 1)); else pass_cnt++;
            if (chk2 && k >= 2) begin
                total_cnt++; if (rdata2 !== exp2) $display("FAIL %s rdata2 k=%0d got %h want %h", tag, k, rdata2, exp2); else pass_cnt++;
            end
            if (chk1 && k >= 1) begin
                total_cnt++; if (rdata1 !== exp1) $display("FAIL %s rdata1 k=%0d got %h want %h", tag, k, rdata1, exp1); else pass_cnt++;
            end
            if (churn && k == 1) begin
                addr  = 16'($urandom);
                wdata = 16'($urandom);
            end
        end
        if (wr && !err) begin
            m1[a[7:0]]    = d;
            m2[a[7:0]]    = d;
            known[a[7:0]] = 1'b1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        total_cnt++; if (busy2 !== 1'b0) $display("FAIL %s busy2_after_drop got %b want 0", tag, busy2); else pass_cnt++;
        total_cnt++; if (busy1 !== 1'b0) $display("FAIL %s busy1_after_drop got %b want 0", tag, busy1); else pass_cnt++;
        total_cnt++; if ((ready2 | ready1) !== 1'b0) $display("FAIL %s ready_after_drop got %b%b want 00", tag, ready2, ready1); else pass_cnt++;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr      = 16'h0;
        wdata     = 16'h0;
        repeat (3) @(negedge clk);
        total_cnt++; if (rdata2 !== 16'h0) $display("FAIL reset rdata2 got %h want 0000", rdata2); else pass_cnt++;
        total_cnt++; if (rdata1 !== 16'h0) $display("FAIL reset rdata1 got %h want 0000", rdata1); else pass_cnt++;
        total_cnt++; if ({ready2, busy2, err2} !== 3'b000) $display("FAIL reset flags2 got %b want 000", {ready2, busy2, err2}); else pass_cnt++;
        total_cnt++; if ({ready1, busy1, err1} !== 3'b000) $display("FAIL reset flags1 got %b want 000", {ready1, busy1, err1}); else pass_cnt++;
        reset_n = 1'b1;
        @(negedge clk);
        total_cnt++; if ({busy2, busy1} !== 2'b00) $display("FAIL idle_busy got %b want 00", {busy2, busy1}); else pass_cnt++;
    endtask

    task automatic test_preload();
        for (int i = 0; i < 32; i++) begin
            do_txn(1'b0, 1'b1, 16'(i), 16'($urandom), 0, 1'b0, "preload");
        end
    endtask

    task automatic test_write_read();
        do_txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, "wr_beef");
        do_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 0, 1'b0, "rd_beef");
    endtask

    task automatic test_latency1();
        do_txn(1'b0, 1'b1, 16'h0003, 16'h1234, 0, 1'b0, "wr_1234");
        do_txn(1'b1, 1'b0, 16'h0003, 16'h0000, 0, 1'b0, "rd_1234");
    endtask

    task automatic test_held_strobe();
        do_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 10, 1'b0, "held_rd");
    endtask

    task automatic test_errors();
        do_txn(1'b0, 1'b1, 16'h0100, 16'hDEAD, 0, 1'b0, "wr_oor");
        do_txn(1'b1, 1'b0, 16'h0000, 16'h0000, 0, 1'b0, "rd_mem0");
        do_txn(1'b1, 1'b0, 16'hFFFF, 16'h0000, 0, 1'b0, "rd_oor");
        do_txn(1'b1, 1'b1, 16'h0004, 16'h5555, 0, 1'b0, "conflict");
        do_txn(1'b1, 1'b0, 16'h0004, 16'h0000, 0, 1'b0, "rd_mem4");
    endtask

    task automatic test_churn();
        do_txn(1'b0, 1'b1, 16'h0007, 16'h00AA, 1, 1'b1, "churn_wr7");
        for (int i = 0; i < 32; i++) begin
            do_txn(1'b1, 1'b0, 16'(i), 16'h0000, 0, 1'b0, "scan");
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] newval;
        newval    = ~m2[5];
        $display("txn reset_abort wr addr=0005 wdata=%h", newval);
        mem_write = 1'b1;
        addr      = 16'h0005;
        wdata     = newval;
        @(posedge clk);
        @(negedge clk);
        total_cnt++; if ({ready2, busy2} !== 2'b01) $display("FAIL abort_wait2 ready/busy got %b want 01", {ready2, busy2}); else pass_cnt++;
        reset_n = 1'b0;
        #1;
        total_cnt++; if ({rdata2, ready2, busy2, err2} !== 19'h0) $display("FAIL abort_async2 got %h/%b%b%b want 0", rdata2, ready2, busy2, err2); else pass_cnt++;
        total_cnt++; if ({rdata1, ready1, busy1, err1} !== 19'h0) $display("FAIL abort_async1 got %h/%b%b%b want 0", rdata1, ready1, busy1, err1); else pass_cnt++;
        mem_write = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        // The LATENCY=1 unit commits at its accept edge, before the reset.
        m1[5] = newval;
        do_txn(1'b1, 1'b0, 16'h0005, 16'h0000, 0, 1'b0, "rd_after_abort");
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            int          sel;
            logic        rd, wr;
            logic [15:0] a;
            sel = int'($urandom_range(0, 9));
            a   = 16'($urandom_range(0, 31));
            rd  = 1'($urandom);
            wr  = ~rd;
            if (sel == 0) begin
                rd = 1'b1;
                wr = 1'b1;
            end else if (sel == 1) begin
                a = 16'($urandom_range(256, 65535));
            end
            do_txn(rd, wr, a, 16'($urandom), int'($urandom_range(0, 2)), 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_latency1();
        test_held_strobe();
        test_errors();
        test_churn();
        test_reset_abort();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Word-addressed data memory that sits on the memory side of the multicycle control unit's MemRead/MemWrite strobes.
- Latches one read or write request, inserts a programmable number of wait states, then returns a one-cycle ready pulse with read data.
- The pulse lets the control FSM stall its MEM state until the access completes.
- Flags out-of-range and conflicting requests instead of corrupting storage.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 16, address width (word address)
- DEPTH, 256, number of words; power of two, must be ≤ 2^ADDR_W
- LATENCY, 2, cycles from request accept to mem_ready; legal range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- mem_read  in  1  read request, level; held by requester until mem_ready
- mem_write  in  1  write request, level; held by requester until mem_ready
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data; valid only while mem_ready=1
- mem_ready  out  1  one-cycle completion pulse
- mem_busy  out  1  high from accept through completion, until the request drops
- mem_err  out  1  high with mem_ready when the access was rejected

Behaviour:
- Reset (reset_n=0, asynchronous):
  - State goes to IDLE.
  - rdata=0, mem_ready=0, mem_busy=0, mem_err=0, wait counter=0.
  - Storage array is not cleared.
  - Reset mid-transaction aborts it; a pending write is not committed.
- States:
  - IDLE: no transaction.
  - WAIT: counting wait states.
  - RESP: one cycle, mem_ready=1.
  - HOLD: waiting for the request to drop.
- All outputs are registered.
- IDLE:
  - If mem_read|mem_write is high at a rising edge (cycle T), accept the request.
  - On accept, latch addr, wdata and the op. Later input changes are ignored.
  - Load counter = LATENCY-1.
  - Go to WAIT, or directly to RESP when LATENCY=1.
  - mem_busy rises at the accept edge.
- WAIT: decrement the counter each cycle; at 0 go to RESP.
- Latency: mem_ready is high in exactly one cycle, T+LATENCY.
- RESP:
  - Read: rdata = mem[latched addr], presented in the same cycle as mem_ready.
  - Write: mem[latched addr] is written at the edge entering RESP.
  - RESP → HOLD unconditionally.
  - mem_ready falls after one cycle; rdata holds its value until the next RESP.
- HOLD:
  - Stay while mem_read|mem_write is high; go to IDLE when both are low.
  - mem_busy falls when entering IDLE.
  - This prevents a still-asserted strobe from re-triggering the access.
- Error cases (mem_err=1 in the RESP cycle):
  - Out of range: latched addr ≥ DEPTH gives no write, rdata=0.
  - Conflict: both mem_read and mem_write high at accept gives no access, rdata=0.
  - Latency is unchanged for error responses.
- Index: mem index = addr[$clog2(DEPTH)-1:0], used only after the range check.
- Request changes during WAIT are ignored (already latched). Requests arriving in HOLD are not queued.
- Back-to-back: the earliest next accept is two cycles after mem_ready (HOLD → IDLE → accept).

Decomposition:
- Shared package (mem_pkg):
  - state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10, HOLD=2'b11)
  - DATA_W/ADDR_W defaults
  - op encodings (OP_RD, OP_WR, OP_BAD)
- Sub-module mem_array: synchronous-write, combinational-read DEPTH×DATA_W storage with a write-enable port.
- Responder FSM, counter and error logic stay in data_mem_responder.

Test Plan:
- Reset: assert reset_n=0 mid-WAIT of a write to addr 5 → outputs all 0 immediately; after release, reading addr 5 returns the prior contents (write not committed).
- Write then read, LATENCY=2:
  - mem_write=1, addr=0x0010, wdata=0xBEEF at T → mem_ready=1 only at T+2, mem_err=0.
  - Drop the strobe, then mem_read addr 0x0010 → rdata=0xBEEF with mem_ready.
- LATENCY=1: mem_read addr 3 after writing 0x1234 → mem_ready at T+1, rdata=0x1234, exactly one-cycle pulse.
- Held strobe: keep mem_read=1 for 10 cycles after mem_ready → no second mem_ready, mem_busy stays 1 until the strobe drops, then 0 next cycle.
- Errors:
  - mem_write addr 0x0100 (DEPTH=256) → mem_err=1 with mem_ready at T+LATENCY, and mem[0] unchanged.
  - mem_read=mem_write=1 → mem_err=1, rdata=0.
- Input churn: change addr/wdata during WAIT of a write to addr 7 with 0x00AA → mem[7]=0x00AA, no other location modified.
